// File: rtl/xts_tweak_engine.sv
// XTS whitening stage around the Serpent core: pre/post-XOR with tweak T,
// advancing T by alpha in GF(2^128) after each block of a sector.
module xts_tweak_engine #(
  parameter int MAX_BLKS    = 32,
  parameter int CNT_W       = 6,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sector_start,
  input  logic [127:0]     i_tweak,
  input  logic             i_blk_valid,
  output logic             o_blk_ready,
  input  logic [127:0]     i_blk_data,
  input  logic             i_blk_last,
  output logic             o_core_start,
  output logic [127:0]     o_core_data,
  input  logic [127:0]     i_core_data,
  input  logic             i_core_valid,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [127:0]     o_out_data,
  output logic             o_out_last,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_blk_count,
  output logic             o_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  // Counter is cleared in CORE_START, so this limit places o_err exactly
  // TIMEOUT_CYC cycles after the start pulse.
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYC - 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_BLK   = 3'd1,
    S_CORE_START = 3'd2,
    S_CORE_WAIT  = 3'd3,
    S_OUT_HOLD   = 3'd4
  } state_t;

  function automatic logic [127:0] gf_mul_alpha(input logic [127:0] t);
    gf_mul_alpha = {t[126:0], 1'b0} ^ (t[127] ? 128'h87 : 128'h0);
  endfunction

  state_t           state_q, state_d;
  logic [127:0]     tweak_q, tweak_d;
  logic [127:0]     core_data_q, core_data_d;
  logic [127:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             last_q, last_d;
  logic             core_start_q, core_start_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Next-state and datapath decode for the whitening sequencer
  always_comb begin
    state_d     = state_q;
    tweak_d     = tweak_q;
    core_data_d = core_data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_sector_start) begin
          tweak_d = i_tweak;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_WAIT_BLK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_BLK: begin
        if (i_blk_valid) begin
          core_data_d = i_blk_data ^ tweak_q;
          last_d      = i_blk_last | (cnt_q == LAST_IDX);
          state_d     = S_CORE_START;
        end else begin
          state_d = S_WAIT_BLK;
        end
      end
      S_CORE_START: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = S_CORE_WAIT;
      end
      S_CORE_WAIT: begin
        if (i_core_valid) begin
          out_data_d  = i_core_data ^ tweak_q;
          out_valid_d = 1'b1;
          out_last_d  = last_q;
          tweak_d     = gf_mul_alpha(tweak_q);
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = S_OUT_HOLD;
        end else if (tmo_q == TMO_LIM) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_OUT_HOLD: begin
        if (i_out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = last_q ? S_IDLE : S_WAIT_BLK;
        end else begin
          state_d = S_OUT_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    core_start_d = (state_d == S_CORE_START);
    busy_d       = (state_d != S_IDLE);
  end

  // State, tweak and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      tweak_q      <= 128'h0;
      core_data_q  <= 128'h0;
      out_data_q   <= 128'h0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      last_q       <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      tmo_q        <= {TMO_W{1'b0}};
    end else begin
      state_q      <= state_d;
      tweak_q      <= tweak_d;
      core_data_q  <= core_data_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      last_q       <= last_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  assign o_blk_ready  = (state_q == S_WAIT_BLK);
  assign o_core_start = core_start_q;
  assign o_core_data  = core_data_q;
  assign o_out_valid  = out_valid_q;
  assign o_out_data   = out_data_q;
  assign o_out_last   = out_last_q;
  assign o_busy       = busy_q;
  assign o_blk_count  = cnt_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_xts_tweak_engine.sv
// Directed bench for xts_tweak_engine with a behavioural Serpent core stub.
module tb_xts_tweak_engine;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_sector_start = 1'b0;
  logic [127:0] i_tweak = 128'h0;
  logic         i_blk_valid = 1'b0;
  logic         o_blk_ready;
  logic [127:0] i_blk_data = 128'h0;
  logic         i_blk_last = 1'b0;
  logic         o_core_start;
  logic [127:0] o_core_data;
  logic [127:0] i_core_data;
  logic         i_core_valid = 1'b0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b0;
  logic [127:0] o_out_data;
  logic         o_out_last;
  logic         o_busy;
  logic [5:0]   o_blk_count;
  logic         o_err;

  int errors = 0;
  int checks = 0;
  int stub_mode = 0;  // 0 identity, 1 constant all-ones, 2 silent
  int stub_cnt = 0;

  localparam logic [127:0] P   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] P2  = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam logic [127:0] P5  = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;

  xts_tweak_engine dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sector_start(i_sector_start), .i_tweak(i_tweak),
    .i_blk_valid(i_blk_valid), .o_blk_ready(o_blk_ready), .i_blk_data(i_blk_data),
    .i_blk_last(i_blk_last), .o_core_start(o_core_start), .o_core_data(o_core_data),
    .i_core_data(i_core_data), .i_core_valid(i_core_valid), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_busy(o_busy), .o_blk_count(o_blk_count), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Core stub: result valid for one cycle, five cycles after the start pulse
  assign i_core_data = (stub_mode == 1) ? {128{1'b1}} : o_core_data;
  always @(posedge i_clk) begin
    #1;
    if (o_core_start) stub_cnt = 5;
    else if (stub_cnt != 0) stub_cnt = stub_cnt - 1;
    i_core_valid = (stub_cnt == 1) && (stub_mode != 2);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {o_blk_ready, o_core_start, o_out_valid, o_out_last, o_busy, o_err, o_blk_count}, 128'h0);
    chk({tag, "_core_data"}, o_core_data, 128'h0);
    chk({tag, "_out_data"}, o_out_data, 128'h0);
  endtask

  task automatic start_sector(input logic [127:0] t);
    i_sector_start = 1'b1;
    i_tweak = t;
    tick();
    i_sector_start = 1'b0;
  endtask

  task automatic offer(input string tag, input logic [127:0] d, input logic l);
    int n;
    n = 0;
    i_blk_valid = 1'b1;
    i_blk_data = d;
    i_blk_last = l;
    while (!o_blk_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, o_blk_ready, 128'h1);
    tick();
    i_blk_valid = 1'b0;
    i_blk_last = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!o_out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_out_valid"}, o_out_valid, 128'h1);
  endtask

  task automatic release_out();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [127:0] d;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    i_rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Single block, T0 = 1, identity core
    stub_mode = 0;
    start_sector(128'h1);
    chk("t1_busy_ready", {o_busy, o_blk_ready}, 128'h3);
    offer("t1", P, 1'b1);
    chk("t1_core_start", o_core_start, 128'h1);
    chk("t1_core_data", o_core_data, P ^ 128'h1);
    wait_out("t1");
    chk("t1_out_data", o_out_data, P);
    chk("t1_out_last", o_out_last, 128'h1);
    chk("t1_count", o_blk_count, 128'h1);
    release_out();
    chk("t1_idle", {o_busy, o_out_valid, o_out_last, o_blk_ready}, 128'h0);

    // T0 with top bit set: second tweak is 0x87
    start_sector(128'h8000_0000_0000_0000_0000_0000_0000_0000);
    offer("t2a", P, 1'b0);
    chk("t2a_core_data", o_core_data, P ^ 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    wait_out("t2a");
    chk("t2a_out", {o_out_data, 1'b0} >> 1, P);
    chk("t2a_last", o_out_last, 128'h0);
    release_out();
    offer("t2b", P2, 1'b1);
    chk("t2b_core_data", o_core_data, P2 ^ 128'h87);
    wait_out("t2b");
    chk("t2b_out", o_out_data, P2);
    chk("t2b_count", o_blk_count, 128'h2);
    release_out();

    // Constant all-ones core, T0 = 2
    stub_mode = 1;
    start_sector(128'h2);
    offer("t3", 128'h0, 1'b1);
    wait_out("t3");
    chk("t3_out", o_out_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD);
    release_out();

    // Full 32-block sector, last never driven
    stub_mode = 0;
    start_sector(128'h1);
    for (int i = 0; i < 32; i++) begin
      d = {4{32'(i) * 32'h0101_0101 + 32'h1357_9BDF}};
      offer("t4", d, 1'b0);
      wait_out("t4");
      chk("t4_out", o_out_data, d);
      chk("t4_last", o_out_last, (i == 31) ? 128'h1 : 128'h0);
      release_out();
    end
    chk("t4_count", o_blk_count, 128'd32);
    chk("t4_idle", o_busy, 128'h0);
    i_blk_valid = 1'b1;
    i_blk_data = P;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_no_accept", {o_blk_ready, o_core_start, o_busy}, 128'h0);
    end
    i_blk_valid = 1'b0;
    chk("t4_count_hold", o_blk_count, 128'd32);

    // Downstream back-pressure for 10 cycles
    start_sector(128'h3);
    offer("t5", P5, 1'b1);
    wait_out("t5");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold_data", o_out_data, P5);
      chk("t5_hold_ctrl", {o_out_valid, o_blk_ready, o_core_start}, 128'h4);
    end
    release_out();

    // Silent core: timeout
    stub_mode = 2;
    start_sector(128'h1);
    offer("t6", P, 1'b1);
    chk("t6_core_start", o_core_start, 128'h1);
    n = 0;
    while (!o_err && n < 1100) begin
      tick();
      n++;
    end
    chk("t6_err_cycle", n, 128'd1023);
    chk("t6_busy_valid", {o_busy, o_out_valid}, 128'h0);
    tick();
    chk("t6_err_pulse", o_err, 128'h0);

    // Reset in the middle of CORE_WAIT
    stub_mode = 0;
    start_sector(128'h1);
    offer("t7", P, 1'b1);
    tick();
    tick();
    chk("t7_busy", o_busy, 128'h1);
    #2 i_rst = 1'b1;
    #1;
    chk_all_zero("t7_rst");
    #2 i_rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_out_valid) n++;
    end
    chk("t7_no_out", n, 128'h0);
    chk("t7_idle", o_busy, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xts_tweak_engine.md
Name: xts_tweak_engine

Overview:
- XTS-mode wrapper stage that sits around serpent_top.
- Accepts 128-bit sector data blocks from the upstream sector buffer.
- Pre-whitens each block with the current tweak T and issues it to the Serpent core.
- Post-whitens the core result with the same T and presents it downstream.
- Advances T by multiplication by alpha in GF(2^128) after every block.
- The encrypted initial tweak T0 (E_K2(sector number)) is supplied by the sector controller.

Parameters:
- MAX_BLKS, 32, maximum blocks per sector (512-byte sector); the block at index MAX_BLKS-1 is forced last.
- CNT_W, 6, width of the block counter; must satisfy 2^CNT_W > MAX_BLKS.
- TIMEOUT_CYC, 1023, maximum cycles to wait for the core result before aborting.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_sector_start  in  1  one-cycle pulse; latch i_tweak and begin a sector
- i_tweak  in  128  encrypted initial tweak T0; i_tweak[7:0] is byte 0 (little-endian integer)
- i_blk_valid  in  1  upstream block valid
- o_blk_ready  out  1  engine can accept a block
- i_blk_data  in  128  plaintext or ciphertext block
- i_blk_last  in  1  final block of the sector
- o_core_start  out  1  one-cycle start pulse to the core (drives i_serpent_start)
- o_core_data  out  128  whitened block to the core; held stable until the result returns
- i_core_data  in  128  core output (o_data)
- i_core_valid  in  1  core result valid (o_data_valid)
- o_out_valid  out  1  downstream result valid
- i_out_ready  in  1  downstream accepts the result
- o_out_data  out  128  result block = core output XOR T
- o_out_last  out  1  result is the final block of the sector
- o_busy  out  1  high in every state except IDLE
- o_blk_count  out  CNT_W  blocks completed in the current sector
- o_err  out  1  one-cycle pulse on core timeout

Behaviour:
- Reset (i_rst high, asynchronous): state IDLE. All outputs are 0: o_blk_ready, o_core_start, o_core_data, o_out_valid, o_out_data, o_out_last, o_busy, o_blk_count, o_err. Tweak register is 0.
- States: IDLE, WAIT_BLK, CORE_START, CORE_WAIT, OUT_HOLD.
- IDLE:
  - On i_sector_start: T <= i_tweak, o_blk_count <= 0, go to WAIT_BLK.
  - i_sector_start in any other state is ignored.
- WAIT_BLK:
  - o_blk_ready = 1, combinationally decoded from state.
  - On i_blk_valid: o_core_data <= i_blk_data ^ T.
  - last_r <= i_blk_last | (o_blk_count == MAX_BLKS-1).
  - Go to CORE_START.
- CORE_START:
  - o_core_start = 1 for exactly this cycle; clear the timeout counter; go to CORE_WAIT.
- CORE_WAIT:
  - i_core_valid is treated as a level; only the first cycle it is high is used.
  - On i_core_valid: o_out_data <= i_core_data ^ T, o_out_valid <= 1, o_out_last <= last_r.
  - In the same cycle: T <= {T[126:0],1'b0} ^ (T[127] ? 128'h87 : 0), and o_blk_count increments.
  - Then go to OUT_HOLD.
  - If the timeout counter reaches TIMEOUT_CYC with no i_core_valid: o_err pulses one cycle, go to IDLE, o_out_valid stays 0.
- OUT_HOLD:
  - o_out_valid, o_out_data and o_out_last are held stable.
  - On i_out_ready: o_out_valid <= 0 and o_out_last <= 0. Go to IDLE if last_r, else go to WAIT_BLK.
- Latency: block accept to o_out_valid = core latency + 2 cycles.
- The core always sees at least 2 idle cycles between result and next start, which covers the core's return to its idle state.
- o_core_data is unchanged from WAIT_BLK acceptance until the next acceptance; the core samples i_data throughout its operation.
- Encrypt and decrypt are identical in this block; direction is selected at the core (i_ena_en_de) by the controller.
- Partial blocks (ciphertext stealing) are not supported.
- Reset mid-operation aborts immediately. The core result that follows is ignored, because the state is IDLE.

Test Plan:
- Identity core stub (5-cycle latency), T0 = 128'h1, single block P = 128'h0123...CDEF with last=1:
  - o_core_data = P ^ 1; o_out_data = P; o_out_last = 1; o_blk_count = 1.
  - Returns to IDLE one cycle after i_out_ready.
- T0 = 128'h8000_0000_0000_0000_0000_0000_0000_0000, two blocks:
  - Second block o_core_data = P2 ^ 128'h87.
- Core stub returning constant 128'hFFFF...FF, T0 = 128'h2:
  - o_out_data = 128'hFFFF...FD.
- 32-block sector with i_blk_last never asserted:
  - 32nd result has o_out_last = 1, o_blk_count = 32, then IDLE.
  - A 33rd offered block is not accepted.
- i_out_ready held low for 10 cycles:
  - o_out_data is stable; o_blk_ready = 0; no o_core_start.
- Core stub never responds:
  - o_err pulses at cycle TIMEOUT_CYC after o_core_start; o_busy falls.
- i_rst asserted mid CORE_WAIT:
  - All outputs are 0 immediately; a later i_core_valid produces no o_out_valid.
